// File: rtl/membus_pkg.sv
// Shared definitions for the 6502 / block-copy DMA RAM-port arbiter.
// State encoding, bus-mux select values and the byte-count helper used by
// both the top level and the transfer counter.
package membus_pkg;

  // Arbiter FSM states (3-bit encoding)
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SYNC = 3'd1,
    READ      = 3'd2,
    WRITE     = 3'd3,
    DONE      = 3'd4
  } state_t;

  // RAM-port mux select: who owns mem_addr/mem_rw/mem_wdata this cycle
  localparam logic CPU_SEL = 1'b0;
  localparam logic DMA_SEL = 1'b1;

  // Remaining-byte counter must hold 256 (a length of 0 means 256)
  localparam int CNT_W = 9;

  // Convert the 8-bit length field to a byte count; 0 encodes 256
  function automatic logic [CNT_W-1:0] len_to_count(input logic [7:0] len);
    return (len == 8'd0) ? CNT_W'(256) : CNT_W'(len);
  endfunction

endpackage

// File: rtl/dma_xfer_counter.sv
// Address / length / burst bookkeeping for one DMA transfer.
// Holds the running source and destination pointers, the number of bytes
// still to move and the number moved in the current grant. o_last and
// o_burst_hit describe the byte being written in the current cycle, so the
// FSM can pick its next state in the same WRITE cycle.
module dma_xfer_counter
  import membus_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int BURST  = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_src,
  input  logic [ADDR_W-1:0] i_dst,
  input  logic [7:0]        i_len,
  input  logic              i_step,
  input  logic              i_step_src,
  output logic [ADDR_W-1:0] o_src,
  output logic [ADDR_W-1:0] o_dst,
  output logic              o_last,
  output logic              o_burst_hit
);

  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [CNT_W-1:0]  r_count;

  // Pointers and remaining-byte count: load on start, advance once per written byte
  always_ff @(posedge clk) begin
    if (clr) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_src   <= i_src;
      r_dst   <= i_dst;
      r_count <= len_to_count(i_len);
    end else if (i_step) begin
      // Pointers wrap naturally at the top of the address space
      if (i_step_src) begin
        r_src <= r_src + 1'b1;
      end
      r_dst   <= r_dst + 1'b1;
      r_count <= r_count - 1'b1;
    end
  end

  assign o_src  = r_src;
  assign o_dst  = r_dst;
  assign o_last = (r_count == CNT_W'(1));

  generate
    if (BURST == 0) begin : g_unlimited
      // No burst limit: the bus is held until the whole block is moved
      assign o_burst_hit = 1'b0;
    end else begin : g_burst
      localparam int BCNT_W = (BURST < 2) ? 1 : $clog2(BURST);

      logic [BCNT_W-1:0] r_burst_cnt;
      logic              w_hit;

      // The byte being written now is the last one this grant may move
      assign w_hit = (r_burst_cnt == BCNT_W'(BURST - 1));

      // Bytes moved in the current grant; wraps to 0 when the grant is released
      always_ff @(posedge clk) begin
        if (clr || i_load) begin
          r_burst_cnt <= '0;
        end else if (i_step) begin
          r_burst_cnt <= w_hit ? '0 : r_burst_cnt + 1'b1;
        end
      end

      assign o_burst_hit = w_hit;
    end
  endgenerate

endmodule

// File: rtl/membus_dma_arbiter.sv
// RAM-port arbiter between the 6502 core and a block-copy DMA engine.
// The DMA takes the bus only after an opcode-fetch (sync) cycle, stalls the
// core with cpu_rdy while it alternates READ/WRITE cycles, and hands the bus
// back when the block is done or the burst limit is reached.
// Optional fill mode (constant-byte writes, one cycle per byte) is built
// when MEMBUS_DMA_FILL_EN is defined.
module membus_dma_arbiter
  import membus_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int BURST  = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rw,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_sync,
  output logic              cpu_rdy,
  input  logic              dma_start,
  input  logic [ADDR_W-1:0] dma_src,
  input  logic [ADDR_W-1:0] dma_dst,
  input  logic [7:0]        dma_len,
`ifdef MEMBUS_DMA_FILL_EN
  input  logic              dma_fill,
  input  logic [DATA_W-1:0] dma_fill_data,
`endif
  output logic              dma_busy,
  output logic              dma_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_data;
  logic              r_fill;

  logic              w_load;
  logic              w_step;
  logic              w_sel;
  logic              w_dma_drive;
  logic              w_fill_in;
  logic [DATA_W-1:0] w_fill_data;
  logic [ADDR_W-1:0] w_src;
  logic [ADDR_W-1:0] w_dst;
  logic              w_last;
  logic              w_burst_hit;

`ifdef MEMBUS_DMA_FILL_EN
  assign w_fill_in   = dma_fill;
  assign w_fill_data = dma_fill_data;
`else
  assign w_fill_in   = 1'b0;
  assign w_fill_data = '0;
`endif

  dma_xfer_counter #(
    .ADDR_W (ADDR_W),
    .BURST  (BURST)
  ) u_cnt (
    .clk         (clk),
    .clr         (clr),
    .i_load      (w_load),
    .i_src       (dma_src),
    .i_dst       (dma_dst),
    .i_len       (dma_len),
    .i_step      (w_step),
    .i_step_src  (!r_fill),
    .o_src       (w_src),
    .o_dst       (w_dst),
    .o_last      (w_last),
    .o_burst_hit (w_burst_hit)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Transfer mode and data latch: fill byte on start, RAM read data in READ
  always_ff @(posedge clk) begin
    if (clr) begin
      r_fill <= 1'b0;
      r_data <= '0;
    end else if (w_load) begin
      r_fill <= w_fill_in;
      r_data <= w_fill_in ? w_fill_data : '0;
    end else if (r_state == READ) begin
      r_data <= mem_rdata;
    end
  end

  // Next-state logic plus core stall / status outputs
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_sel        = CPU_SEL;
    cpu_rdy      = 1'b1;
    dma_busy     = 1'b1;
    dma_done     = 1'b0;
    case (r_state)
      IDLE: begin
        dma_busy = 1'b0;
        if (dma_start) begin
          w_load       = 1'b1;
          w_state_next = WAIT_SYNC;
        end
      end
      WAIT_SYNC: begin
        // Grant only on an opcode fetch; a sync flagged on a write is bogus
        if (cpu_sync && cpu_rw) begin
          w_state_next = r_fill ? WRITE : READ;
        end
      end
      READ: begin
        cpu_rdy      = 1'b0;
        w_sel        = DMA_SEL;
        w_state_next = WRITE;
      end
      WRITE: begin
        cpu_rdy = 1'b0;
        w_sel   = DMA_SEL;
        w_step  = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end else if (w_burst_hit) begin
          // Release so the core gets at least one instruction in
          w_state_next = WAIT_SYNC;
        end else if (r_fill) begin
          w_state_next = WRITE;
        end else begin
          w_state_next = READ;
        end
      end
      DONE: begin
        dma_done     = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        dma_busy     = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  // A clear arriving during a DMA cycle hands the port back at once, so the
  // write in progress never reaches RAM and the abort is truly immediate.
  assign w_dma_drive = (w_sel == DMA_SEL) && !clr;

  // RAM-port mux: DMA pointers in READ/WRITE, straight core pass-through otherwise
  always_comb begin
    mem_addr  = cpu_addr;
    mem_rw    = cpu_rw;
    mem_wdata = cpu_wdata;
    if (w_dma_drive) begin
      mem_addr  = (r_state == WRITE) ? w_dst : w_src;
      mem_rw    = (r_state != WRITE);
      mem_wdata = r_data;
    end
  end

endmodule

// File: doc/membus_dma_arbiter.md
Name: membus_dma_arbiter

Overview:
- Shares the single RAM port between the 6502 core and a block-copy DMA engine.
- Takes the bus only at instruction boundaries: waits for a `sync` opcode-fetch cycle, then stalls the core via `cpu_rdy`.
- Copies `dma_len` bytes from `src` to `dst` using alternating read and write cycles, then hands the bus back.
- Sits between the core's address/data registers and `ram` on the board.

Parameters:
- ADDR_W, 16, address width of `cpu_addr`, `mem_addr`, `dma_src` and `dma_dst`.
- DATA_W, 8, data width.
- BURST, 8, max bytes moved per grant; 0 means unlimited (no release until done).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  synchronous active-high reset.
- cpu_addr  input  ADDR_W  core address bus ({abh,abl}).
- cpu_rw  input  1  core direction (1=read, 0=write).
- cpu_wdata  input  DATA_W  core write data (data output register).
- cpu_sync  input  1  core opcode-fetch cycle marker.
- cpu_rdy  output  1  0 stalls the core (core holds all state).
- dma_start  input  1  one-cycle start request.
- dma_src  input  ADDR_W  source start address, sampled on accepted start.
- dma_dst  input  ADDR_W  destination start address, sampled on accepted start.
- dma_len  input  8  byte count, sampled on accepted start; 0 means 256.
- dma_busy  output  1  high from accepted start until the DONE cycle inclusive.
- dma_done  output  1  one-cycle completion pulse.
- mem_addr  output  ADDR_W  RAM address.
- mem_rw  output  1  RAM direction (1=read).
- mem_wdata  output  DATA_W  RAM write data.
- mem_rdata  input  DATA_W  RAM read data, valid combinationally within the cycle.

Behaviour:
- Reset:
  - State IDLE; `cpu_rdy`=1; `dma_busy`=0; `dma_done`=0.
  - Internal src/dst/count/burst counters and data latch cleared.
  - `mem_*` pass through the CPU side.
  - `clr` mid-transfer aborts immediately, with no pulse on `dma_done`; a partial copy is left in RAM.
- Bus mux:
  - In READ and WRITE, `mem_*` are driven from DMA values.
  - In all other states, `mem_addr`=`cpu_addr`, `mem_rw`=`cpu_rw`, `mem_wdata`=`cpu_wdata`.
- `cpu_rdy` is 0 exactly in READ and WRITE; otherwise 1.
- IDLE:
  - `dma_start`=1 latches src/dst/len; `count`=len (0 loads 256); `burst_cnt` cleared; go to WAIT_SYNC.
  - `dma_busy` rises the next cycle.
  - `dma_start` in any non-IDLE state is ignored.
- WAIT_SYNC:
  - Bus belongs to the CPU.
  - At an edge where `cpu_sync`=1 and `cpu_rw`=1, go to READ.
  - The core's opcode fetch completes in that cycle; the core stalls from the next cycle.
- READ:
  - `mem_addr`=src, `mem_rw`=1.
  - On the edge, latch `mem_rdata` into the data latch; go to WRITE.
- WRITE:
  - `mem_addr`=dst, `mem_rw`=0, `mem_wdata`=latch.
  - On the edge: src+=1 and dst+=1 (mod 2^ADDR_W, FFFF wraps to 0000); count-=1; `burst_cnt`+=1.
  - Next state:
    - count reaches 0: DONE.
    - else BURST≠0 and `burst_cnt`==BURST: WAIT_SYNC, with `burst_cnt` cleared so the core runs at least one instruction.
    - else READ.
- DONE: `dma_done`=1 for one cycle, `dma_busy`=1, bus to CPU; next IDLE.
- Throughput: 2 cycles per byte while granted.
- Latency from start to first READ: at least 2 cycles (IDLE→WAIT_SYNC, plus the sync wait).
- Overlapping src/dst ranges: copy is strictly ascending, byte by byte; no overlap correction.
- `cpu_sync` with `cpu_rw`=0 (should not occur) does not grant.

Optional Feature:
- Macro MEMBUS_DMA_FILL_EN.
- Defined:
  - Adds input `dma_fill` (1) and input `dma_fill_data` (DATA_W), both sampled on accepted start.
  - A fill transfer skips READ: WAIT_SYNC→WRITE, WRITE→WRITE.
  - Writes the latched fill byte; src neither used nor incremented; 1 cycle per byte.
  - Burst rules unchanged.
- Undefined: ports absent; always copy mode.

Decomposition:
- Package `membus_pkg`: state localparams (IDLE, WAIT_SYNC, READ, WRITE, DONE, 3-bit encoding) and the mux-select constants CPU_SEL and DMA_SEL.
- One sub-module, `dma_xfer_counter`, holds src/dst/count/burst_cnt with load/step controls and a last/burst_hit flag.
- The FSM and bus mux stay in the top.

Test Plan:
- Copy: RAM[1000..1003]=11,22,33,44; start src=1000, dst=2000, len=4; `cpu_sync` pulsed after 3 cycles.
  -> `cpu_rdy` low for 8 cycles; RAM[2000..2003]=11,22,33,44; single `dma_done` pulse; `cpu_rdy` high the same cycle.
- Sync gating: start with `cpu_sync` held 0 for 20 cycles.
  -> `dma_busy`=1, `cpu_rdy`=1, `mem_addr` follows `cpu_addr` throughout; transfer begins only after `cpu_sync`.
- Burst release, BURST=2, len=5:
  -> three grants of 2, 2 and 1 bytes; `cpu_rdy` rises between grants until the next `cpu_sync`; all 5 bytes correct.
- Wrap and len=0: src=FFFE, dst=0100, len=0.
  -> 256 bytes copied; src wraps FFFF→0000; `dma_done` after 512 granted cycles.
- Reset mid-operation: `clr`=1 during the third WRITE.
  -> next cycle IDLE, `cpu_rdy`=1, `dma_busy`=0, no `dma_done`; exactly 2 destination bytes written.
- Busy start ignored (with MEMBUS_DMA_FILL_EN):
  -> second `dma_start` during a transfer has no effect.
  -> fill run len=3, data=A5, dst=3000 writes A5 to 3000..3002 in 3 granted cycles.
